mano_io_ctrl: RTL and testbench

MANO_IO_CTRL -- requirements
Module: mano_io_ctrl

---
 rtl/mano_io_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mano_io_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mano_io_ctrl.sv
// mano_io_ctrl: Mano-style multi-channel I/O flag block with INPR/OUTR per channel,
// CPU command decode (inp/out/ski/sko/ion/iof) and a registered interrupt request.
// Build option: define MANO_IO_RR_ARB_EN for round-robin interrupt arbitration;
// without it the lowest-index requesting channel wins.
module mano_io_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NCH    = 4,
  localparam int unsigned CH_W  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        dev_in_valid,
  input  logic [NCH*DATA_W-1:0] dev_in_data,
  output logic [NCH-1:0]        dev_in_ready,
  output logic [NCH*DATA_W-1:0] dev_out_data,
  output logic [NCH-1:0]        dev_out_valid,
  input  logic [NCH-1:0]        dev_out_ack,
  input  logic [CH_W-1:0]       cpu_ch,
  input  logic                  cpu_inp,
  input  logic                  cpu_out,
  input  logic                  cpu_ski,
  input  logic                  cpu_sko,
  input  logic                  cpu_ion,
  input  logic                  cpu_iof,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_skip,
  input  logic                  intr_ack,
  output logic                  irq,
  output logic [CH_W-1:0]       irq_ch,
  output logic                  ien
);

  localparam int unsigned CHX_W = CH_W + 1;

  logic [DATA_W-1:0] inpr [NCH];
  logic [DATA_W-1:0] outr [NCH];
  logic [NCH-1:0]    fgi, fgo, fgi_nxt, fgo_nxt;
  logic [NCH-1:0]    cap, wr, hit, req;
  logic              ch_ok, any_req, ien_nxt;
  logic              sel_inp, sel_out, sel_ski, sel_sko, sel_ion, sel_iof;
  logic [CH_W-1:0]   win;

  assign dev_in_ready  = ~fgi;
  assign dev_out_valid = ~fgo;
  assign req           = fgi | fgo;
  assign any_req       = |req;
  assign ch_ok         = ({1'b0, cpu_ch} < CHX_W'(NCH));

  // Pack the output registers onto the device bus
  always_comb begin
    dev_out_data = '0;
    for (int i = 0; i < NCH; i++) dev_out_data[i*DATA_W +: DATA_W] = outr[i];
  end

  // CPU strobe priority: only the highest asserted command executes
  always_comb begin
    sel_inp = cpu_inp;
    sel_out = cpu_out & ~cpu_inp;
    sel_ski = cpu_ski & ~cpu_inp & ~cpu_out;
    sel_sko = cpu_sko & ~cpu_inp & ~cpu_out & ~cpu_ski;
    sel_ion = cpu_ion & ~(cpu_inp | cpu_out | cpu_ski | cpu_sko);
    sel_iof = cpu_iof & ~(cpu_inp | cpu_out | cpu_ski | cpu_sko | cpu_ion);
  end

  // One-hot decode of the selected channel; out-of-range selects hit nothing
  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) hit[i] = ch_ok && (cpu_ch == CH_W'(i));
  end

  // Read mux, skip result and per-channel flag next-state
  always_comb begin
    cpu_rdata = '0;
    cpu_skip  = 1'b0;
    fgi_nxt   = fgi;
    fgo_nxt   = fgo;
    cap       = '0;
    wr        = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hit[i]) begin
        cpu_rdata = inpr[i];
        if (sel_ski) cpu_skip = fgi[i];
        if (sel_sko) cpu_skip = fgo[i];
      end
      if (sel_inp && hit[i]) begin
        fgi_nxt[i] = 1'b0;
      end else if (dev_in_valid[i] && !fgi[i]) begin
        cap[i]     = 1'b1;
        fgi_nxt[i] = 1'b1;
      end
      if (sel_out && hit[i] && fgo[i]) begin
        wr[i]      = 1'b1;
        fgo_nxt[i] = 1'b0;
      end else if (dev_out_ack[i] && !fgo[i]) begin
        fgo_nxt[i] = 1'b1;
      end
    end
  end

  // Interrupt enable: intr_ack beats ion; irq uses the updated enable so it drops with the ack
  always_comb begin
    ien_nxt = ien;
    if (sel_ion) ien_nxt = 1'b1;
    if (sel_iof) ien_nxt = 1'b0;
    if (intr_ack) ien_nxt = 1'b0;
  end

`ifdef MANO_IO_RR_ARB_EN
  logic [CH_W-1:0] rr_ptr;
  logic [NCH-1:0]  rot;

  assign rot = NCH'({req, req} >> rr_ptr);

  // Round-robin winner: first requester at or above the pointer, wrapping
  always_comb begin
    win = irq_ch;
    for (int k = NCH - 1; k >= 0; k--)
      if (rot[k]) win = CH_W'((int'(rr_ptr) + k) % int'(NCH));
  end

  // Pointer advances past the acknowledged channel only while a request was raised
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (intr_ack && irq) begin
      rr_ptr <= (irq_ch == CH_W'(NCH - 1)) ? '0 : irq_ch + CH_W'(1);
    end
  end
`else
  // Fixed priority winner: lowest requesting index
  always_comb begin
    win = irq_ch;
    for (int k = NCH - 1; k >= 0; k--)
      if (req[k]) win = CH_W'(k);
  end
`endif

  // State registers: flags, data registers and interrupt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fgi    <= '0;
      fgo    <= '1;
      ien    <= 1'b0;
      irq    <= 1'b0;
      irq_ch <= '0;
      for (int i = 0; i < NCH; i++) begin
        inpr[i] <= '0;
        outr[i] <= '0;
      end
    end else begin
      fgi <= fgi_nxt;
      fgo <= fgo_nxt;
      ien <= ien_nxt;
      irq <= ien_nxt & any_req;
      if (any_req) irq_ch <= win;
      for (int i = 0; i < NCH; i++) begin
        if (cap[i]) inpr[i] <= dev_in_data[i*DATA_W +: DATA_W];
        if (wr[i])  outr[i] <= cpu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mano_io_ctrl.sv
// Self-checking bench for mano_io_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the I/O flag rules.
// Honors MANO_IO_RR_ARB_EN the same way as the design.
module tb_mano_io_ctrl;
  localparam int DW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  dev_in_valid, dev_in_ready, dev_out_valid, dev_out_ack;
  logic [N*DW-1:0] dev_in_data, dev_out_data;
  logic [1:0]    cpu_ch, irq_ch;
  logic          cpu_inp, cpu_out, cpu_ski, cpu_sko, cpu_ion, cpu_iof;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_skip, intr_ack, irq, ien;

  mano_io_ctrl #(.DATA_W(DW), .NCH(N)) dut (
    .clk(clk), .rst(rst),
    .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data), .dev_in_ready(dev_in_ready),
    .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ack(dev_out_ack),
    .cpu_ch(cpu_ch), .cpu_inp(cpu_inp), .cpu_out(cpu_out), .cpu_ski(cpu_ski),
    .cpu_sko(cpu_sko), .cpu_ion(cpu_ion), .cpu_iof(cpu_iof), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_skip(cpu_skip), .intr_ack(intr_ack), .irq(irq),
    .irq_ch(irq_ch), .ien(ien)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [DW-1:0] m_inpr [N];
  logic [DW-1:0] m_outr [N];
  bit            m_fgi [N];
  bit            m_fgo [N];
  bit            m_ien, m_irq;
  int            m_irq_ch, m_ptr;

  int checks, failures;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Executed command after priority: 1 inp, 2 out, 3 ski, 4 sko, 5 ion, 6 iof, 0 none
  function automatic int cmd_sel();
    if (cpu_inp) return 1;
    if (cpu_out) return 2;
    if (cpu_ski) return 3;
    if (cpu_sko) return 4;
    if (cpu_ion) return 5;
    if (cpu_iof) return 6;
    return 0;
  endfunction

  task automatic idle();
    rst = 1'b0; dev_in_valid = '0; dev_in_data = '0; dev_out_ack = '0;
    cpu_ch = 2'd0; cpu_inp = 0; cpu_out = 0; cpu_ski = 0; cpu_sko = 0;
    cpu_ion = 0; cpu_iof = 0; cpu_wdata = '0; intr_ack = 0;
  endtask

  // Compare all DUT outputs against the model for the current cycle
  task automatic check_model();
    logic [N-1:0]    e_rdy, e_ov;
    logic [N*DW-1:0] e_od;
    int c;
    bit e_sk;
    for (int i = 0; i < N; i++) begin
      e_rdy[i] = !m_fgi[i];
      e_ov[i]  = !m_fgo[i];
      e_od[i*DW +: DW] = m_outr[i];
    end
    c = cmd_sel();
    e_sk = (c == 3) ? m_fgi[cpu_ch] : (c == 4) ? m_fgo[cpu_ch] : 1'b0;
    chk("dev_in_ready", 64'(dev_in_ready), 64'(e_rdy));
    chk("dev_out_valid", 64'(dev_out_valid), 64'(e_ov));
    chk("dev_out_data", 64'(dev_out_data), 64'(e_od));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(m_inpr[cpu_ch]));
    chk("cpu_skip", 64'(cpu_skip), 64'(e_sk));
    chk("ien", 64'(ien), 64'(m_ien));
    chk("irq", 64'(irq), 64'(m_irq));
    chk("irq_ch", 64'(irq_ch), 64'(m_irq_ch));
  endtask

  // Apply one clock edge of the specification rules to the model
  task automatic model_edge();
    int c, win;
    bit any, new_ien;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_fgi[i] = 0; m_fgo[i] = 1; m_inpr[i] = '0; m_outr[i] = '0;
      end
      m_ien = 0; m_irq = 0; m_irq_ch = 0; m_ptr = 0;
      return;
    end
    c = cmd_sel();
    any = 0;
    win = m_irq_ch;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_fgi[j] || m_fgo[j]) begin any = 1; win = j; end
    end
    new_ien = intr_ack ? 1'b0 : (c == 5) ? 1'b1 : (c == 6) ? 1'b0 : m_ien;
`ifdef MANO_IO_RR_ARB_EN
    if (intr_ack && m_irq) m_ptr = (m_irq_ch + 1) % N;
`endif
    for (int i = 0; i < N; i++) begin
      bit sel;
      sel = (int'(cpu_ch) == i);
      if (c == 1 && sel) m_fgi[i] = 0;
      else if (dev_in_valid[i] && !m_fgi[i]) begin
        m_fgi[i] = 1; m_inpr[i] = dev_in_data[i*DW +: DW];
      end
      if (c == 2 && sel && m_fgo[i]) begin
        m_fgo[i] = 0; m_outr[i] = cpu_wdata;
      end else if (dev_out_ack[i] && !m_fgo[i]) m_fgo[i] = 1;
    end
    m_ien = new_ien;
    m_irq = new_ien && any;
    if (any) m_irq_ch = win;
  endtask

  task automatic settle();
    #1 check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    idle();
    rst = 1'b1; dev_in_valid = 4'b0001; dev_in_data = 32'h0000_00FF;
    @(negedge clk);
    edge_step();

    // Idle after reset: every OUTR free, no input held, interrupts off
    idle();
    settle();
    chk("rst_out_valid", 64'(dev_out_valid), 64'h0);
    chk("rst_in_ready", 64'(dev_in_ready), 64'hF);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_ien", 64'(ien), 64'h0);
    chk("rst_inpr0", 64'(cpu_rdata), 64'h0);
    edge_step();

    // Device input on channel 2, skip then read it
    idle(); dev_in_valid = 4'b0100; dev_in_data = 32'h00AB_0000;
    settle(); edge_step();
    idle(); cpu_ch = 2'd2; cpu_ski = 1;
    settle(); chk("ski_ch2", 64'(cpu_skip), 64'h1); edge_step();
    idle(); cpu_ch = 2'd2; cpu_inp = 1;
    settle(); chk("inp_rdata", 64'(cpu_rdata), 64'hAB); edge_step();
    idle();
    settle(); chk("fgi2_clear", 64'(dev_in_ready[2]), 64'h1); edge_step();

    // Output on channel 1, blocked overwrite, device ack
    idle(); cpu_ch = 2'd1; cpu_out = 1; cpu_wdata = 8'h5C;
    settle(); edge_step();
    idle();
    settle();
    chk("out1_valid", 64'(dev_out_valid[1]), 64'h1);
    chk("out1_data", 64'(dev_out_data[15:8]), 64'h5C);
    edge_step();
    idle(); cpu_ch = 2'd1; cpu_out = 1; cpu_wdata = 8'h11;
    settle(); edge_step();
    idle();
    settle(); chk("out1_no_overwrite", 64'(dev_out_data[15:8]), 64'h5C); edge_step();
    idle(); dev_out_ack = 4'b0010;
    settle(); edge_step();
    idle();
    settle(); chk("out1_acked", 64'(dev_out_valid[1]), 64'h0); edge_step();

    // Interrupt with FGI[1], FGI[3] set and every OUTR busy
    for (int ch = 0; ch < N; ch++) begin
      idle(); cpu_ch = 2'(ch); cpu_out = 1; cpu_wdata = 8'(ch + 8'h30);
      settle(); edge_step();
    end
    idle(); dev_in_valid = 4'b1010; dev_in_data = 32'h3300_1100; cpu_ion = 1;
    settle(); edge_step();
    idle();
    settle(); edge_step();
    idle();
    settle();
    chk("irq_raised", 64'(irq), 64'h1);
    chk("irq_ch_first", 64'(irq_ch), 64'h1);
    edge_step();
    idle(); intr_ack = 1;
    settle(); edge_step();
    idle();
    settle();
    chk("ack_ien", 64'(ien), 64'h0);
    chk("ack_irq", 64'(irq), 64'h0);
    edge_step();
    idle(); cpu_ion = 1;
    settle(); edge_step();
    idle();
    settle();
    chk("irq_again", 64'(irq), 64'h1);
`ifdef MANO_IO_RR_ARB_EN
    chk("irq_ch_rr", 64'(irq_ch), 64'h3);
`else
    chk("irq_ch_fixed", 64'(irq_ch), 64'h1);
`endif
    edge_step();

    // inp and ion together: only inp executes
    idle(); cpu_iof = 1;
    settle(); edge_step();
    idle(); cpu_ch = 2'd0; cpu_inp = 1; cpu_ion = 1;
    settle(); edge_step();
    idle();
    settle(); chk("inp_beats_ion", 64'(ien), 64'h0); edge_step();

    // Reset beats a simultaneous device capture
    idle(); rst = 1; dev_in_valid = 4'b0001; dev_in_data = 32'h0000_00FF;
    settle(); edge_step();
    idle();
    settle();
    chk("rst_fgi0", 64'(dev_in_ready[0]), 64'h1);
    chk("rst_inpr0_again", 64'(cpu_rdata), 64'h0);
    edge_step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst          = ($urandom_range(0, 199) == 0);
      dev_in_valid = 4'($urandom);
      dev_in_data  = $urandom;
      dev_out_ack  = 4'($urandom);
      cpu_ch       = 2'($urandom);
      cpu_wdata    = 8'($urandom);
      cpu_inp      = ($urandom_range(0, 5) == 0);
      cpu_out      = ($urandom_range(0, 4) == 0);
      cpu_ski      = ($urandom_range(0, 4) == 0);
      cpu_sko      = ($urandom_range(0, 4) == 0);
      cpu_ion      = ($urandom_range(0, 5) == 0);
      cpu_iof      = ($urandom_range(0, 9) == 0);
      intr_ack     = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      settle();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
